mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/burst_beat_counter.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory-port arbiter.
package mem_arb_pkg;

  localparam int BEAT_BYTES          = 8;
  localparam int DEFAULT_BLOCK_WORDS = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT_I = 2'd1,
    ST_GRANT_D = 2'd2,
    ST_DONE    = 2'd3
  } arb_state_t;

endpackage

// File: rtl/burst_beat_counter.sv
// Beat index within a cache-line burst: load to zero, advance on enable,
// flag the final beat.
module burst_beat_counter #(
  parameter int BLOCK_WORDS = 8
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic                           i_load,
  input  logic                           i_en,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_count,
  output logic                           o_tc
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);

  logic [IDX_W-1:0] cnt_q, cnt_d;

  // NOTE: every path assigns cnt_d a default first, so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (i_load) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + IDX_W'(1);
    end
  end

  // NOTE: registers use non-blocking assignment so all flops see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_count = cnt_q;
  assign o_tc    = (cnt_q == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between I-cache fills and D-cache fills/writebacks,
// moving whole cache lines as bursts of 8-byte beats.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH  = 64,
  parameter int DATA_WIDTH  = 64,
  parameter int BLOCK_WORDS = DEFAULT_BLOCK_WORDS
) (
  input  logic                           i_clk,
  input  logic                           i_arst,
  input  logic                           i_icache_req,
  input  logic [ADDR_WIDTH-1:0]          i_icache_addr,
  input  logic                           i_dcache_req,
  input  logic                           i_dcache_we,
  input  logic [ADDR_WIDTH-1:0]          i_dcache_addr,
  input  logic [DATA_WIDTH-1:0]          i_dcache_wdata,
  input  logic                           i_mem_ready,
  input  logic [DATA_WIDTH-1:0]          i_mem_rdata,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [ADDR_WIDTH-1:0]          o_mem_addr,
  output logic [DATA_WIDTH-1:0]          o_mem_wdata,
  output logic [$clog2(BLOCK_WORDS)-1:0] o_beat_idx,
  output logic                           o_icache_valid,
  output logic                           o_dcache_valid,
  output logic [DATA_WIDTH-1:0]          o_rdata,
  output logic                           o_icache_done,
  output logic                           o_dcache_done,
  output logic                           o_busy
);

  localparam int IDX_W      = $clog2(BLOCK_WORDS);
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'(BLOCK_WORDS * BEAT_BYTES - 1);

  arb_state_t             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic                   we_q, we_d;
  logic                   own_dcache_q, own_dcache_d;
  logic                   starved_q, starved_d;
  logic                   cnt_load, cnt_en, cnt_tc;
  logic [IDX_W-1:0]       beat_idx;
  logic                   in_grant;

  assign in_grant = (state_q == ST_GRANT_I) || (state_q == ST_GRANT_D);
  assign cnt_en   = in_grant && i_mem_ready;

  burst_beat_counter #(.BLOCK_WORDS(BLOCK_WORDS)) u_beat_cnt (
    .i_clk   (i_clk),
    .i_arst  (i_arst),
    .i_load  (cnt_load),
    .i_en    (cnt_en),
    .o_count (beat_idx),
    .o_tc    (cnt_tc)
  );

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      we_q         <= 1'b0;
      own_dcache_q <= 1'b0;
      starved_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      we_q         <= we_d;
      own_dcache_q <= own_dcache_d;
      starved_q    <= starved_d;
    end
  end

  // D normally wins a tie; once I has lost a tie it wins the next one.
  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    we_d         = we_q;
    own_dcache_d = own_dcache_q;
    starved_d    = starved_q;
    cnt_load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_dcache_req && !(i_icache_req && starved_q)) begin
          state_d      = ST_GRANT_D;
          base_d       = i_dcache_addr & LINE_MASK;
          we_d         = i_dcache_we;
          own_dcache_d = 1'b1;
          starved_d    = starved_q | i_icache_req;
          cnt_load     = 1'b1;
        end else if (i_icache_req) begin
          state_d      = ST_GRANT_I;
          base_d       = i_icache_addr & LINE_MASK;
          we_d         = 1'b0;
          own_dcache_d = 1'b0;
          starved_d    = 1'b0;
          cnt_load     = 1'b1;
        end
      end
      ST_GRANT_I, ST_GRANT_D: begin
        if (i_mem_ready && cnt_tc) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_mem_req      = 1'b0;
    o_mem_we       = 1'b0;
    o_mem_addr     = '0;
    o_mem_wdata    = '0;
    o_beat_idx     = '0;
    o_icache_valid = 1'b0;
    o_dcache_valid = 1'b0;
    o_rdata        = '0;
    o_icache_done  = 1'b0;
    o_dcache_done  = 1'b0;
    o_busy         = 1'b0;
    if (!i_arst) begin
      o_busy     = (state_q != ST_IDLE);
      o_mem_we   = we_q;
      o_beat_idx = beat_idx;
      o_rdata    = i_mem_rdata;
      if (in_grant) begin
        o_mem_req  = 1'b1;
        o_mem_addr = base_q + ADDR_WIDTH'({beat_idx, {BEAT_SHIFT{1'b0}}});
      end
      if (state_q == ST_GRANT_D && we_q) begin
        o_mem_wdata = i_dcache_wdata;
      end
      o_icache_valid = (state_q == ST_GRANT_I) && i_mem_ready && !we_q;
      o_dcache_valid = (state_q == ST_GRANT_D) && i_mem_ready && !we_q;
      o_icache_done  = (state_q == ST_DONE) && !own_dcache_q;
      o_dcache_done  = (state_q == ST_DONE) && own_dcache_q;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

  localparam int BW = 8;
  localparam int IW = $clog2(BW);
  localparam logic [63:0] LINE = 64'(BW * 8);

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic          ireq = 1'b0, dreq = 1'b0, dwe = 1'b0, rdy = 1'b0;
  logic [63:0]   iaddr = '0, daddr = '0, dwdata = '0, rdata_in = '0;

  logic          mem_req, mem_we, ivalid, dvalid, idone, ddone, busy;
  logic [63:0]   mem_addr, mem_wdata, rdata;
  logic [IW-1:0] beat_idx;

  mem_port_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BLOCK_WORDS(BW)) dut (
    .i_clk          (clk),
    .i_arst         (arst),
    .i_icache_req   (ireq),
    .i_icache_addr  (iaddr),
    .i_dcache_req   (dreq),
    .i_dcache_we    (dwe),
    .i_dcache_addr  (daddr),
    .i_dcache_wdata (dwdata),
    .i_mem_ready    (rdy),
    .i_mem_rdata    (rdata_in),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_beat_idx     (beat_idx),
    .o_icache_valid (ivalid),
    .o_dcache_valid (dvalid),
    .o_rdata        (rdata),
    .o_icache_done  (idone),
    .o_dcache_done  (ddone),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the burst in flight, described as owner/line/beat.
  bit          m_busy = 0, m_done = 0, m_own_d = 0, m_we = 0, m_starved = 0;
  logic [63:0] m_base = '0;
  int          m_beat = 0;

  // Observations from the most recent sampled cycle.
  bit          last_idone = 0, last_ddone = 0, obs_req = 0, obs_we = 0, obs_busy = 0;
  logic [63:0] obs_addr = '0;
  int          n_ivalid = 0, n_dvalid = 0, n_idone = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit g;
    g = m_busy && !m_done;
    if (arst) begin
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_beat_idx", 64'(beat_idx), 0);
      check("rst_valids", {ivalid, dvalid}, 0);
      check("rst_dones", {idone, ddone}, 0);
      check("rst_rdata", rdata, 0);
      check("rst_busy", busy, 0);
    end else begin
      check("mem_req", mem_req, g);
      check("busy", busy, m_busy);
      check("icache_valid", ivalid, g && !m_own_d && rdy && !m_we);
      check("dcache_valid", dvalid, g && m_own_d && rdy && !m_we);
      check("icache_done", idone, m_done && !m_own_d);
      check("dcache_done", ddone, m_done && m_own_d);
      check("rdata", rdata, rdata_in);
      if (g) begin
        check("mem_addr", mem_addr, m_base + 64'(8 * m_beat));
        check("beat_idx", 64'(beat_idx), 64'(m_beat));
        check("mem_we", mem_we, m_we);
        if (m_own_d && m_we) check("mem_wdata", mem_wdata, dwdata);
      end
    end
    last_idone = idone;
    last_ddone = ddone;
    obs_req    = mem_req;
    obs_we     = mem_we;
    obs_busy   = busy;
    obs_addr   = mem_addr;
    n_ivalid  += int'(ivalid);
    n_dvalid  += int'(dvalid);
    n_idone   += int'(idone);
  endtask

  task automatic advance_model();
    bit i_wins;
    if (arst) begin
      m_busy = 0; m_done = 0; m_starved = 0; m_we = 0; m_beat = 0; m_base = '0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (m_busy) begin
      if (rdy) begin
        if (m_beat == BW - 1) m_done = 1;
        else m_beat++;
      end
    end else begin
      i_wins = ireq && (!dreq || m_starved);
      if (i_wins) begin
        m_busy = 1; m_own_d = 0; m_we = 0; m_beat = 0;
        m_base = (iaddr / LINE) * LINE;
        m_starved = 0;
      end else if (dreq) begin
        m_busy = 1; m_own_d = 1; m_we = dwe; m_beat = 0;
        m_base = (daddr / LINE) * LINE;
        if (ireq) m_starved = 1;
      end
    end
  endtask

  // Inputs set after step() returns are the ones sampled at the next edge.
  task automatic step();
    @(negedge clk);
    check_outputs();
    advance_model();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit is_d, input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    while (!seen && n < 200) begin
      step();
      n++;
      seen = is_d ? last_ddone : last_idone;
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic drive_random();
    bit i_own, d_own;
    i_own    = m_busy && !m_done && !m_own_d;
    d_own    = m_busy && !m_done && m_own_d;
    arst     = ($urandom_range(0, 249) == 0);
    rdy      = ($urandom_range(0, 3) != 0);
    rdata_in = {$urandom, $urandom};
    dwdata   = {$urandom, $urandom};
    if (last_idone) begin
      ireq  = ($urandom_range(0, 3) == 0);
      iaddr = {$urandom, $urandom};
    end else if (!ireq && !i_own) begin
      if ($urandom_range(0, 5) == 0) begin ireq = 1; iaddr = {$urandom, $urandom}; end
    end else if (ireq && i_own && $urandom_range(0, 9) == 0) begin
      ireq = 0;
    end
    if (last_ddone) begin
      dreq  = ($urandom_range(0, 3) == 0);
      daddr = {$urandom, $urandom};
      dwe   = $urandom_range(0, 1) == 1;
    end else if (!dreq && !d_own) begin
      if ($urandom_range(0, 5) == 0) begin
        dreq = 1; daddr = {$urandom, $urandom}; dwe = $urandom_range(0, 1) == 1;
      end
    end else if (dreq && d_own && $urandom_range(0, 9) == 0) begin
      dreq = 0;
    end
  endtask

  initial begin
    logic [63:0] b_addr;
    int n, snap;

    // Reset holds every output low.
    step();
    step();
    arst = 0;
    step();

    // I fill alone, ready every cycle.
    ireq = 1; iaddr = 64'h1234; rdy = 1; n_ivalid = 0;
    step();
    step();
    check("i_first_addr", obs_addr, 64'h1200);
    wait_done(0, "i_alone");
    check("i_alone_valid_cnt", n_ivalid, BW);
    ireq = 0;
    step();

    // Simultaneous requests: D writeback first, I two cycles after D done.
    ireq = 1; iaddr = {$urandom, $urandom};
    dreq = 1; dwe = 1; daddr = {$urandom, $urandom}; dwdata = {$urandom, $urandom};
    step();
    step();
    check("tie_d_first_we", obs_we, 1);
    wait_done(1, "tie_d");
    dreq = 0;
    step();
    check("tie_gap_idle", obs_req, 0);
    step();
    check("tie_i_start_req", obs_req, 1);
    check("tie_i_start_we", obs_we, 0);
    wait_done(0, "tie_i");
    ireq = 0;
    step();

    // Starvation guard: D keeps re-requesting while I waits.
    dreq = 1; dwe = 1; daddr = {$urandom, $urandom}; ireq = 0;
    step();
    step();
    b_addr = {$urandom, $urandom};
    ireq = 1; iaddr = b_addr;
    wait_done(1, "starve_d1");
    daddr = {$urandom, $urandom};
    step();
    step();
    check("starve_second_is_d", obs_we, 1);
    wait_done(1, "starve_d2");
    daddr = {$urandom, $urandom};
    step();
    step();
    check("starve_third_we", obs_we, 0);
    check("starve_third_addr", obs_addr, (b_addr / LINE) * LINE);
    wait_done(0, "starve_i");
    ireq = 0;
    wait_done(1, "starve_d3");
    dreq = 0;
    step();

    // D read with ready toggling 1,0,1,0.
    dreq = 1; dwe = 0; daddr = 64'h8040; n_dvalid = 0; n = 0; rdy = 1;
    step();
    last_ddone = 0;
    while (!last_ddone && n < 60) begin
      rdy = (n % 2 == 0);
      rdata_in = {$urandom, $urandom};
      step();
      n++;
    end
    check("toggle_done_seen", last_ddone, 1);
    check("toggle_valid_cnt", n_dvalid, BW);
    dreq = 0; rdy = 1;
    step();

    // Reset at beat 3 of an I fill abandons the burst.
    ireq = 1; iaddr = {$urandom, $urandom}; n = 0;
    while (!(m_busy && !m_done && m_beat == 3) && n < 50) begin step(); n++; end
    check("rst_mid_reached_beat3", 64'(m_beat), 3);
    snap = n_idone;
    arst = 1;
    step();
    arst = 0; ireq = 0;
    step();
    check("rst_mid_req_low", obs_req, 0);
    check("rst_mid_idle", obs_busy, 0);
    repeat (12) step();
    check("rst_mid_no_done", n_idone - snap, 0);
    dreq = 1; dwe = 0; daddr = {$urandom, $urandom};
    wait_done(1, "rst_mid_d");
    dreq = 0;
    step();

    // I request dropped at beat 2 still completes.
    ireq = 1; iaddr = {$urandom, $urandom}; n_ivalid = 0; n = 0;
    while (!(m_busy && !m_done && m_beat == 2) && n < 50) begin step(); n++; end
    ireq = 0;
    wait_done(0, "drop_i");
    check("drop_i_valid_cnt", n_ivalid, BW);
    step();

    // Random traffic.
    repeat (3000) begin
      drive_random();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
